// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: the pipeline-facing request/response
// channel and the word-addressed data-memory channel.
interface lsu_req_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_err;
   logic [31:0]   rsp_rdata;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

interface lsu_mem_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_e_write;
   logic [31:0] mem_read_data;

   modport master (
      output mem_addr, mem_write_data, mem_e_write,
      input  mem_read_data
   );

   modport slave (
      input  mem_addr, mem_write_data, mem_e_write,
      output mem_read_data
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word access to a word-addressed memory
// with extension, sub-word read-modify-write and error rejection.
// Optional perf counters are enabled by defining LSU_PERF_CNT_EN.
module load_store_unit #(
   parameter int DEPTH = 1024,
   parameter int AW    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_req_if.slave    req,
   lsu_mem_if.master   mem,
   output logic [31:0] load_count,
   output logic [31:0] store_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WRITE,
      S_RESP
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

   state_e      state_q, state_d;
   logic        write_q, write_d;
   size_e       size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lane_q, lane_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Request legality, evaluated on the live inputs at the accept edge.
   always_comb begin
      req_err = 1'b0;
      unique case (size_e'(req.req_size))
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req.req_addr[0];
         SZ_WORD: req_err = |req.req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if ({2'b00, req.req_addr[AW-1:2]} >= DEPTH_LIM) begin
         req_err = 1'b1;
      end
   end

   // Lane extraction and extension for loads.
   always_comb begin
      unique case (lane_q)
         2'd0:    byte_sel = mem.mem_read_data[7:0];
         2'd1:    byte_sel = mem.mem_read_data[15:8];
         2'd2:    byte_sel = mem.mem_read_data[23:16];
         default: byte_sel = mem.mem_read_data[31:24];
      endcase
      half_sel = lane_q[1] ? mem.mem_read_data[31:16] : mem.mem_read_data[15:0];
      unique case (size_q)
         SZ_BYTE: load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_ext = mem.mem_read_data;
      endcase
   end

   // Sub-word store merge: store data was latched right-aligned in mem_wdata_q.
   always_comb begin
      merged = mem.mem_read_data;
      if (size_q == SZ_BYTE) begin
         unique case (lane_q)
            2'd0:    merged[7:0]   = mem_wdata_q[7:0];
            2'd1:    merged[15:8]  = mem_wdata_q[7:0];
            2'd2:    merged[23:16] = mem_wdata_q[7:0];
            default: merged[31:24] = mem_wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = mem_wdata_q[15:0];
      end else begin
         merged[15:0] = mem_wdata_q[15:0];
      end
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first so no path leaves a latch behind.
      state_d     = state_q;
      write_d     = write_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (req.req_valid) begin
               write_d    = req.req_write;
               size_d     = size_e'(req.req_size);
               uns_d      = req.req_unsigned;
               lane_d     = req.req_addr[1:0];
               err_d      = req_err;
               rdata_d    = '0;
               mem_addr_d = 32'(req.req_addr[AW-1:2]);
               if (req.req_write && !req_err) begin
                  mem_wdata_d = req.req_wdata;
               end
               state_d = req_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!write_q) begin
               rdata_d = load_ext;
               state_d = S_RESP;
            end else if (size_q == SZ_WORD) begin
               state_d = S_RESP;
            end else begin
               mem_wdata_d = merged;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         lane_q      <= 2'd0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
         state_q     <= state_d;
         write_q     <= write_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Write enable decodes straight from state so an async reset kills it at once.
   assign mem.mem_e_write    = (state_q == S_WRITE) ||
                               (state_q == S_ACCESS && write_q && size_q == SZ_WORD);
   assign mem.mem_addr       = mem_addr_q;
   assign mem.mem_write_data = mem_wdata_q;

   assign req.req_ready = (state_q == S_IDLE);
   assign req.rsp_valid = (state_q == S_RESP);
   assign req.rsp_err   = (state_q == S_RESP) && err_q;
   assign req.rsp_rdata = rdata_q;

`ifdef LSU_PERF_CNT_EN
   logic [31:0] load_cnt_q, store_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
      end else if (state_q == S_RESP && !err_q) begin
         if (write_q) store_cnt_q <= store_cnt_q + 32'd1;
         else         load_cnt_q  <= load_cnt_q + 32'd1;
      end
   end

   assign load_count  = load_cnt_q;
   assign store_count = store_cnt_q;
`else
   assign load_count  = '0;
   assign store_count = '0;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface, sitting in the MEM stage between the pipeline and the word-addressed data memory.
- The memory has a combinational read, a synchronous write and a write enable.
- Accepts byte-addressed load/store requests of byte, halfword or word size, then drives the memory's word address, write data and write enable.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and reserved-size requests with an error response instead of touching memory.

Parameters:
- DEPTH, 1024: memory size in 32-bit words; word indices at or above DEPTH are out of range.
- AW, 32: request byte-address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle; request accepted when req_valid && req_ready at posedge.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  valid with rsp_valid; request rejected.
- rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors.
- mem_addr  output  32  word index = {2'b00, latched req_addr[31:2]}.
- mem_write_data  output  32  word to write.
- mem_e_write  output  1  memory write enable.
- mem_read_data  input  32  combinational memory read of mem_addr.
- load_count  output  32  loads completed without error (optional feature).
- store_count  output  32  stores completed without error (optional feature).

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE immediately.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_write_data=0, mem_e_write=0, counters 0.
  - mem_e_write is decoded from state, so reset asserted mid-WRITE drops it in the same instant.
- Lanes are little-endian: byte k = bits [8k+7:8k] at addr[1:0]=k; halfword at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
- Error check in IDLE on accept. Any of the following is an error:
  - req_size==11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- States:
  - IDLE: req_ready=1.
    - On accept, latch the request and load mem_addr.
    - Error -> RESP with rsp_err=1 and no memory access.
    - Otherwise -> ACCESS.
  - ACCESS: req_ready=0.
    - Load: extract lane from mem_read_data, extend, register into rsp_rdata -> RESP.
    - Word store: mem_e_write=1, mem_write_data=wdata -> RESP.
    - Sub-word store: merge low byte/half of wdata into mem_read_data at the lane, register into mem_write_data -> WRITE.
  - WRITE: mem_e_write=1 with the merged word -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. There is no response backpressure.
- Latency (accept at edge T):
  - Error: rsp_valid in the cycle after T.
  - Load / word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Memory write occurs at the edge ending ACCESS or WRITE.
- mem_e_write is 1 only in ACCESS(word store) and WRITE.
- mem_addr holds its last value while IDLE.
- req_ready=0 outside IDLE. Requests presented while busy are ignored, not queued. The pipeline stalls on !req_ready.
- Inputs req_* are don't-care after accept.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: load_count / store_count increment by 1 at the RESP cycle of each non-error load/store. They wrap at 2^32 and are cleared only by reset.
- Undefined: both ports tied to 0 and no counter flops inferred.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load 0x10:
  - mem_e_write=1 with mem_addr=4 one cycle after accept.
  - Load rsp_valid at T+2 with rdata=0xDEADBEEF, err=0.
- Byte store 0x000000AA to 0x11 over word 4 = 0xDEADBEEF:
  - Read then write, mem_write_data=0xDEADAAEF.
  - rsp_valid at T+3.
- Loads from word 4 = 0xDEADAAEF:
  - Byte 0x11 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
  - Half 0x12 signed -> 0xFFFFDEAD.
- Error cases, each giving rsp_valid=1, rsp_err=1, rdata=0 at T+1 and mem_e_write never asserted:
  - Word store to 0x13.
  - Half load at 0x01.
  - size=11.
  - Word load at 0x1000 with DEPTH=1024.
- rst_n pulled low during WRITE of a byte store:
  - mem_e_write drops immediately and the word is unchanged.
  - After release, req_ready=1 and rsp_valid=0.
- Back-to-back: req_valid held high across two requests; the second is accepted only in the cycle after the first's rsp_valid. With LSU_PERF_CNT_EN, three good loads plus one error give load_count=3.
